// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bw_in, one bit per clock, LSB first.
// Start/done handshake; diff and bw_out are held until the next operation completes.
// Optional: define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bw_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bw_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bw_out_q, bw_out_d;

  // Single full-subtractor cell working on the current LSBs.
  logic bit_d, bit_br;
  assign bit_d  = a_q[0] ^ b_q[0] ^ br_q;
  assign bit_br = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept separately because the shift registers lose them.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Next-state, datapath shifting and completion capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    diff_d   = diff_q;
    bw_out_d = bw_out_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bw_in;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      StRun: begin
        res_d = {bit_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bit_br;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d   = {bit_d, res_q[WIDTH-1:1]};
          bw_out_d = bit_br;
          state_d  = StDone;
`ifdef SERIAL_SUB_OVF_EN
          // The last processed bit becomes the result MSB.
          ovf_d    = (a_msb_q ^ b_msb_q) & (a_msb_q ^ bit_d);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      diff_q   <= '0;
      bw_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      diff_q   <= diff_d;
      bw_out_q <= bw_out_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Handshake flags decode directly from the state.
  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  assign diff   = diff_q;
  assign bw_out = bw_out_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random operations
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bw_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bw_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .bw_in  (bw_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bw_out (bw_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed interpretations.
  task automatic ref_sub(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                         input logic rbw, output logic [WIDTH-1:0] rd,
                         output logic rbo, output logic rov);
    longint ua, ub, ur, sa, sb, sr, lim;
    ua  = longint'(ra);
    ub  = longint'(rb);
    ur  = ua - ub - longint'(rbw);
    rd  = WIDTH'(ur);
    rbo = (ur < 0);
    sa  = longint'($signed(ra));
    sb  = longint'($signed(rb));
    sr  = sa - sb - longint'(rbw);
    lim = longint'(1) << (WIDTH - 1);
    rov = (sr >= lim) || (sr < -lim);
  endtask

  // Runs one operation from IDLE and checks handshake timing and results.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb, input logic vbw);
    logic [WIDTH-1:0] ed;
    logic             ebo, eov;
    int               cycles, busy_cnt;
    bit               seen;
    ref_sub(va, vb, vbw, ed, ebo, eov);
    @(negedge clk);
    a = va; b = vb; bw_in = vbw; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Operands may change freely once captured.
    a = WIDTH'($urandom); b = WIDTH'($urandom); bw_in = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    cycles = 0;
    seen = 1'b0;
    for (int k = 0; k < int'(WIDTH) + 4; k++) begin
      @(negedge clk);
      cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, " latency"}, longint'(cycles), longint'(WIDTH));
    check({tag, " busy_cycles"}, longint'(busy_cnt), longint'(WIDTH));
    check({tag, " diff"}, longint'(diff), longint'(ed));
    check({tag, " bw_out"}, longint'(bw_out), longint'(ebo));
    if (seen) check({tag, " busy_at_done"}, longint'(busy), 0);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, longint'(ovf), longint'(eov));
`endif
    @(negedge clk);
    check({tag, " done_single"}, longint'(done), 0);
    check({tag, " diff_held"}, longint'(diff), longint'(ed));
  endtask

  initial begin
    logic [WIDTH-1:0] ed, cap_a, cap_b;
    logic             ebo, eov;
    int               dones;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; bw_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst busy", longint'(busy), 0);
    check("rst done", longint'(done), 0);
    check("rst diff", longint'(diff), 0);
    check("rst bw_out", longint'(bw_out), 0);
    // Simultaneous rst and start: rst wins.
    start = 1'b1;
    @(negedge clk);
    check("rst_start busy", longint'(busy), 0);
    start = 1'b0; rst = 1'b0;

    run_op("ad_d6", 8'hAD, 8'hD6, 1'b0);
    run_op("2d_96", 8'h2D, 8'h96, 1'b0);
    repeat (3) @(negedge clk);
    check("held diff", longint'(diff), 64'h97);
    check("held bw_out", longint'(bw_out), 1);
    run_op("96_2d", 8'h96, 8'h2D, 1'b0);
    run_op("00_00_b", 8'h00, 8'h00, 1'b1);
    run_op("ff_ff", 8'hFF, 8'hFF, 1'b0);
    run_op("80_01", 8'h80, 8'h01, 1'b0);

    // Start held high through RUN and DONE with operands changing every cycle.
    cap_a = 8'h3C; cap_b = 8'hC5;
    ref_sub(cap_a, cap_b, 1'b1, ed, ebo, eov);
    @(negedge clk);
    a = cap_a; b = cap_b; bw_in = 1'b1; start = 1'b1;
    dones = 0;
    for (int k = 0; k <= int'(WIDTH); k++) begin
      @(negedge clk);
      a = WIDTH'($urandom); b = WIDTH'($urandom); bw_in = 1'($urandom);
      if (done) dones++;
    end
    start = 1'b0;
    check("storm dones", longint'(dones), 1);
    check("storm diff", longint'(diff), longint'(ed));
    check("storm bw_out", longint'(bw_out), longint'(ebo));
    // DONE returned to IDLE without accepting the held start.
    check("storm idle", longint'(busy), 0);
    @(negedge clk);
    check("storm still_idle", longint'(busy), 0);
    run_op("after_storm", 8'h10, 8'h20, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h55; b = 8'hAA; bw_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", longint'(busy), 0);
    check("abort done", longint'(done), 0);
    check("abort diff", longint'(diff), 0);
    check("abort bw_out", longint'(bw_out), 0);
    dones = 0;
    for (int k = 0; k < int'(WIDTH) + 3; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", longint'(dones), 0);
    run_op("after_abort", 8'h01, 8'h02, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rand%0d", i), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
